tbuf_bus_arbiter: RTL and testbench



---
 rtl/tbuf_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_tbuf_bus_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tbuf_bus_arbiter.sv
// Registered tri-state bus arbiter: NCH sources share one WIDTH-bit bus with bounded tenure
// and a fixed all-Z turnaround gap. Define TBUF_RR_EN for round-robin, else fixed priority.
module tbuf_bus_arbiter #(
    parameter int WIDTH      = 32,
    parameter int NCH        = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] src_data,
    output logic [NCH-1:0]       grant,
    output tri   [WIDTH-1:0]     data,
    output logic                 bus_busy
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);
    localparam logic [IW-1:0] LAST_CH   = IW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   turn_q, turn_d;
    logic            drive_en;
    logic            any_req;
    logic            arb;
    logic [IW-1:0]   win;
    logic [WIDTH-1:0] src_w [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_src
        assign src_w[g] = src_data[g*WIDTH +: WIDTH];
    end

    assign any_req = |req;

`ifdef TBUF_RR_EN
    logic [IW-1:0] rr_q, rr_d;

    // Scanning downwards from the farthest slot leaves the first requester at or after rr in win.
    always_comb begin
        logic [IW-1:0] idx;
        idx = '0;
        win = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = IW'((int'(rr_q) + i) % NCH);
            if (req[idx]) win = idx;
        end
    end
`else
    always_comb begin
        logic [IW-1:0] idx;
        idx = '0;
        win = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = IW'(i);
            if (req[idx]) win = idx;
        end
    end
`endif

    // NOTE: every output of this block gets a default before the case, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        data_d  = data_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        arb     = 1'b0;
`ifdef TBUF_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: arb = 1'b1;
            GRANT: begin
                if (req[owner_q] && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + 1'b1;
                    data_d = src_w[owner_q];
                end else begin
                    grant_d = '0;
                    turn_d  = '0;
                    state_d = TURN;
                end
            end
            TURN: begin
                if (turn_q != TURN_LAST) begin
                    turn_d = turn_q + 1'b1;
                end else begin
                    arb     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb && any_req) begin
            grant_d = NCH'(1) << win;
            owner_d = win;
            data_d  = src_w[win];
            hold_d  = '0;
            state_d = GRANT;
`ifdef TBUF_RR_EN
            rr_d    = (win == LAST_CH) ? '0 : win + 1'b1;
`endif
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            data_q  <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
`ifdef TBUF_RR_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
`ifdef TBUF_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Bus enable is derived from the grant flops themselves, so grant and drive can never disagree.
    assign drive_en = |grant_q;
    assign grant    = grant_q;
    assign bus_busy = drive_en;
    assign data     = drive_en ? data_q : {WIDTH{1'bz}};

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Randomized bench for tbuf_bus_arbiter, compared every cycle against a tenure/gap model.
// The bus is weakly pulled up here, so an undriven (Z) bus reads as all ones.
module tb_tbuf_bus_arbiter;

    localparam int WIDTH      = 32;
    localparam int NCH        = 4;
    localparam int MAX_HOLD   = 3;
    localparam int TURNAROUND = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCH-1:0]       req = '0;
    logic [NCH*WIDTH-1:0] src_data = '0;
    logic [NCH-1:0]       grant;
    wire  [WIDTH-1:0]     data;
    logic                 bus_busy;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pu
        pullup (data[i]);
    end

    tbuf_bus_arbiter #(
        .WIDTH(WIDTH), .NCH(NCH), .MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data),
        .grant(grant), .data(data), .bus_busy(bus_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: who owns the bus, how long it has held it, and how many idle gap cycles remain.
    int               m_owner = -1;
    int               m_tenure = 0;
    int               m_gap = 0;
    int               m_rr = 0;
    logic [WIDTH-1:0] m_data = '0;

    task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [WIDTH-1:0] word_of(input int c);
        return src_data[c*WIDTH +: WIDTH];
    endfunction

    function automatic logic [NCH*WIDTH-1:0] rand_src();
        logic [NCH*WIDTH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*WIDTH +: WIDTH] = $urandom;
        return v;
    endfunction

    task automatic model_edge();
        int start;
        int c;
        if (!rst_n) begin
            m_owner = -1;
            m_tenure = 0;
            m_gap = 0;
            m_rr = 0;
        end else if (m_owner >= 0) begin
            if (req[m_owner] && m_tenure < MAX_HOLD) begin
                m_tenure++;
                m_data = word_of(m_owner);
            end else begin
                m_owner = -1;
                m_gap = TURNAROUND;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
`ifdef TBUF_RR_EN
            start = m_rr;
`else
            start = 0;
`endif
            for (int k = 0; k < NCH; k++) begin
                c = (start + k) % NCH;
                if (m_owner < 0 && req[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_tenure = 1;
                m_data = word_of(m_owner);
                m_rr = (m_owner + 1) % NCH;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [NCH-1:0] q, input logic [NCH*WIDTH-1:0] s);
        logic [NCH-1:0] eg;
        @(negedge clk);
        rst_n = r;
        req = q;
        src_data = s;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        eg = (m_owner >= 0) ? NCH'(1) << m_owner : '0;
        check("grant", WIDTH'(grant), WIDTH'(eg));
        check("data", data, (m_owner >= 0) ? m_data : {WIDTH{1'b1}});
        check("busy", WIDTH'(bus_busy), WIDTH'(m_owner >= 0));
    endtask

    initial begin
        logic [NCH*WIDTH-1:0] s;
        logic [NCH-1:0]       q;

        // Reset held with every source requesting.
        cycle(1'b0, 4'b1111, rand_src());
        cycle(1'b0, 4'b1111, rand_src());
        check("rst_data_z", data, {WIDTH{1'b1}});

        // Single grant, then the owner's word changes.
        s = rand_src();
        s[2*WIDTH +: WIDTH] = 32'hAAAAAAAA;
        cycle(1'b1, 4'b0100, s);
        check("single_grant", WIDTH'(grant), WIDTH'(4'b0100));
        check("single_data", data, 32'hAAAAAAAA);
        s[2*WIDTH +: WIDTH] = 32'h55555555;
        cycle(1'b1, 4'b0100, s);
        cycle(1'b1, 4'b0100, s);
        check("follow_data", data, 32'h55555555);

        // Continuous single requester: hold limit and gap.
        for (int i = 0; i < 3 * (MAX_HOLD + TURNAROUND); i++) cycle(1'b1, 4'b0001, rand_src());

        // Everyone requesting.
        for (int i = 0; i < 4 * (MAX_HOLD + TURNAROUND) + 2; i++) cycle(1'b1, 4'b1111, rand_src());

        // Owner hand-off: ch1 drops while ch3 raises on the same edge.
        for (int i = 0; i < MAX_HOLD + TURNAROUND + 2; i++) cycle(1'b1, 4'b0000, rand_src());
        cycle(1'b1, 4'b0010, rand_src());
        cycle(1'b1, 4'b0010, rand_src());
        for (int i = 0; i < TURNAROUND + 3; i++) cycle(1'b1, 4'b1000, rand_src());

        // Reset during a tenure, then a two-way request.
        for (int i = 0; i < MAX_HOLD + TURNAROUND + 2; i++) cycle(1'b1, 4'b0000, rand_src());
        cycle(1'b1, 4'b0100, rand_src());
        cycle(1'b0, 4'b0100, rand_src());
        check("midrst_z", data, {WIDTH{1'b1}});
        cycle(1'b1, 4'b0110, rand_src());
        check("post_rst_grant", WIDTH'(grant), WIDTH'(4'b0010));

        // Random traffic with sticky requests and rare resets.
        q = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(5) == 0) q[c] = ~q[c];
            cycle(($urandom_range(149) != 0), q, rand_src());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
